// File: rtl/bus_drive_arbiter_pkg.sv
// Shared definitions for the bus drive arbiter and its round-robin picker.
// Holds the FSM state encoding and the index-width helper.
package bus_drive_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    // $clog2 clamped to at least one bit so single-value counters still exist
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set req bit at or above pointer.
// Ports: req (request levels), pointer (scan start), found, winner (index).
module rr_priority_pick
    import bus_drive_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    pointer,
    output logic             found,
    output logic [IW-1:0]    winner
);

    int idx;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(pointer) + i) % N_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_drive_arbiter.sv
// Round-robin enable generator for tri-state bus drivers with dead gap.
// Ports: clk, rst (sync high), req, bus_en, grant_id, bus_busy, bus_turn.
module bus_drive_arbiter
    import bus_drive_arbiter_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int TURNAROUND = 1,
    parameter int MAX_HOLD   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    output logic [N_REQ-1:0]            bus_en,
    output logic [idx_width(N_REQ)-1:0] grant_id,
    output logic                        bus_busy,
    output logic                        bus_turn
);

    localparam int IW = idx_width(N_REQ);
    // Wide enough to reach MAX_HOLD and still saturate above it
    localparam int HW = idx_width(MAX_HOLD + 2);
    localparam int TW = idx_width(TURNAROUND + 1);

    localparam logic [N_REQ-1:0] ONE       = N_REQ'(1);
    localparam logic [HW-1:0]    HOLD_MAX  = HW'(MAX_HOLD);
    localparam logic [TW-1:0]    TURN_LAST = TW'(TURNAROUND);
    localparam logic [IW-1:0]    LAST_ID   = IW'(N_REQ - 1);

    state_t          state;
    logic [IW-1:0]   pointer;
    logic [HW-1:0]   hold_cnt;
    logic [TW-1:0]   turn_cnt;
    logic            found;
    logic [IW-1:0]   winner;
    logic            owner_rel;
    logic [IW-1:0]   next_ptr;

    rr_priority_pick #(
        .N_REQ(N_REQ)
    ) u_pick (
        .req    (req),
        .pointer(pointer),
        .found  (found),
        .winner (winner)
    );

    assign owner_rel = !req[grant_id] ||
                       ((MAX_HOLD != 0) && (hold_cnt == HOLD_MAX));

    assign next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + IW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pointer  <= '0;
            hold_cnt <= '0;
            turn_cnt <= '0;
            bus_en   <= '0;
            grant_id <= '0;
            bus_busy <= 1'b0;
            bus_turn <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state    <= GRANT;
                        bus_en   <= ONE << winner;
                        grant_id <= winner;
                        bus_busy <= 1'b1;
                        hold_cnt <= HW'(1);
                    end
                end
                GRANT: begin
                    if (owner_rel) begin
                        state    <= TURN;
                        bus_en   <= '0;
                        bus_busy <= 1'b0;
                        bus_turn <= 1'b1;
                        turn_cnt <= TW'(1);
                        pointer  <= next_ptr;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                TURN: begin
                    // Last dead cycle doubles as the arbitration cycle
                    if (turn_cnt == TURN_LAST) begin
                        bus_turn <= 1'b0;
                        if (found) begin
                            state    <= GRANT;
                            bus_en   <= ONE << winner;
                            grant_id <= winner;
                            bus_busy <= 1'b1;
                            hold_cnt <= HW'(1);
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        turn_cnt <= turn_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_drive_arbiter.sv
// Directed and random checks of bus_drive_arbiter in two configurations.
// dut_a: defaults (TURNAROUND=1, MAX_HOLD=8); dut_b: TURNAROUND=2, unlimited.
module tb_bus_drive_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_a = '0;
    logic [3:0] req_b = '0;
    logic [3:0] en_a, en_b;
    logic [1:0] gid_a, gid_b;
    logic       busy_a, busy_b, turn_a, turn_b;

    int total = 0;
    int bad   = 0;

    logic [3:0] last_a = '0;
    logic [3:0] last_b = '0;
    int         zeros_a = 0;
    int         zeros_b = 0;

    always #5 clk = ~clk;

    bus_drive_arbiter dut_a (
        .clk     (clk),
        .rst     (rst),
        .req     (req_a),
        .bus_en  (en_a),
        .grant_id(gid_a),
        .bus_busy(busy_a),
        .bus_turn(turn_a)
    );

    bus_drive_arbiter #(
        .N_REQ     (4),
        .TURNAROUND(2),
        .MAX_HOLD  (0)
    ) dut_b (
        .clk     (clk),
        .rst     (rst),
        .req     (req_b),
        .bus_en  (en_b),
        .grant_id(gid_b),
        .bus_busy(busy_b),
        .bus_turn(turn_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] en,
                              input logic [1:0] gid, input logic turn);
        chk({tag, "_en"}, 32'(en_a), 32'(en));
        chk({tag, "_busy"}, 32'(busy_a), 32'(en != 0));
        chk({tag, "_turn"}, 32'(turn_a), 32'(turn));
        if (en != 0) chk({tag, "_gid"}, 32'(gid_a), 32'(gid));
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req_a = '0;
        tick();
        tick();
        chk("rst_en", 32'(en_a), 0);
        chk("rst_gid", 32'(gid_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_turn", 32'(turn_a), 0);
        rst = 1'b0;
    endtask

    task automatic inv(input string tag, input logic [3:0] en,
                       input logic [1:0] gid, input logic busy,
                       input logic turn, input int ta, input logic r,
                       inout logic [3:0] last, inout int zeros);
        chk({tag, "_onehot"}, 32'($countones(en) <= 1), 1);
        chk({tag, "_busy_or"}, 32'(busy), 32'(|en));
        chk({tag, "_turn_busy"}, 32'(turn && busy), 0);
        if (busy) chk({tag, "_gid_en"}, 32'(en), 32'(4'b0001 << gid));
        if (en != 0) begin
            if (last != 0 && en != last)
                chk({tag, "_gap"}, 32'(zeros >= ta), 1);
            last  = en;
            zeros = 0;
        end else begin
            zeros++;
        end
        if (r) last = '0;
    endtask

    always @(negedge clk) begin
        inv("inv_a", en_a, gid_a, busy_a, turn_a, 1, rst, last_a, zeros_a);
        inv("inv_b", en_b, gid_b, busy_b, turn_b, 2, rst, last_b, zeros_b);
    end

    int         held[4];
    int         lim[4];
    int         wait_cnt[4];
    logic [3:0] prev_en_b;
    int         w;

    initial begin
        do_reset();

        // single source, 1-cycle latency, release into one turn cycle
        req_a = 4'b0001;
        tick();
        expect_out("t1_c1", 4'b0001, 2'd0, 1'b0);
        req_a = 4'b0000;
        tick();
        expect_out("t1_c2", 4'b0000, 2'd0, 1'b1);
        tick();
        expect_out("t1_c3", 4'b0000, 2'd0, 1'b0);

        // source 2 for three cycles, then turn, then idle
        do_reset();
        req_a = 4'b0100;
        for (int c = 1; c <= 3; c++) begin
            tick();
            expect_out("t2_grant", 4'b0100, 2'd2, 1'b0);
        end
        req_a = 4'b0000;
        tick();
        expect_out("t2_turn", 4'b0000, 2'd0, 1'b1);
        tick();
        expect_out("t2_idle", 4'b0000, 2'd0, 1'b0);

        // all requesting: 8-cycle slots, owners 0,1,2,3,0
        do_reset();
        req_a = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            for (int k = 0; k < 8; k++) begin
                tick();
                expect_out("t3_slot", 4'b0001 << (g % 4), 2'(g % 4), 1'b0);
            end
            tick();
            expect_out("t3_gap", 4'b0000, 2'd0, 1'b1);
        end
        req_a = 4'b0000;

        // pointer 0, req 1010: source 1 first, then source 3
        do_reset();
        req_a = 4'b1010;
        tick();
        expect_out("t4_first", 4'b0010, 2'd1, 1'b0);
        req_a = 4'b1000;
        tick();
        expect_out("t4_turn", 4'b0000, 2'd0, 1'b1);
        tick();
        expect_out("t4_second", 4'b1000, 2'd3, 1'b0);

        // reset mid-grant restores pointer to 0
        do_reset();
        req_a = 4'b0100;
        tick();
        expect_out("t5_pre", 4'b0100, 2'd2, 1'b0);
        req_a = 4'b0000;
        tick();
        tick();
        req_a = 4'b0100;
        for (int c = 1; c <= 4; c++) begin
            tick();
            expect_out("t5_grant", 4'b0100, 2'd2, 1'b0);
        end
        rst = 1'b1;
        tick();
        expect_out("t5_rst", 4'b0000, 2'd0, 1'b0);
        chk("t5_rst_gid", 32'(gid_a), 0);
        rst   = 1'b0;
        req_a = 4'b1010;
        tick();
        expect_out("t5_ptr0", 4'b0010, 2'd1, 1'b0);
        rst   = 1'b1;
        req_a = 4'b1000;
        tick();
        rst = 1'b0;
        tick();
        expect_out("t5_win3", 4'b1000, 2'd3, 1'b0);

        // sole requester forced off, wins again after one turn cycle
        do_reset();
        req_a = 4'b0001;
        for (int c = 1; c <= 8; c++) begin
            tick();
            expect_out("t6_hold", 4'b0001, 2'd0, 1'b0);
        end
        tick();
        expect_out("t6_turn", 4'b0000, 2'd0, 1'b1);
        tick();
        expect_out("t6_again", 4'b0001, 2'd0, 1'b0);

        // drop coinciding with MAX_HOLD: pointer advances once only
        do_reset();
        req_a = 4'b0010;
        for (int c = 1; c <= 8; c++) begin
            tick();
            expect_out("t7_hold", 4'b0010, 2'd1, 1'b0);
        end
        req_a = 4'b0000;
        tick();
        expect_out("t7_turn", 4'b0000, 2'd0, 1'b1);
        req_a = 4'b0101;
        tick();
        expect_out("t7_next", 4'b0100, 2'd2, 1'b0);
        req_a = 4'b0000;

        // random levels on dut_b, fairness bound of N_REQ grants
        do_reset();
        for (int i = 0; i < 4; i++) begin
            held[i]     = 0;
            lim[i]      = 1;
            wait_cnt[i] = 0;
        end
        prev_en_b = '0;
        for (int n = 0; n < 10000; n++) begin
            tick();
            if (en_b != 0 && prev_en_b == 0) begin
                w = int'(gid_b);
                chk("fair_req", 32'(req_b[w]), 1);
                chk("fair_wait", 32'(wait_cnt[w] <= 3), 1);
                wait_cnt[w] = 0;
                for (int i = 0; i < 4; i++)
                    if (i != w && req_b[i]) wait_cnt[i]++;
            end
            prev_en_b = en_b;
            for (int i = 0; i < 4; i++) begin
                if (req_b[i]) begin
                    if (en_b[i]) begin
                        held[i]++;
                        if (held[i] >= lim[i]) req_b[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    req_b[i]    = 1'b1;
                    held[i]     = 0;
                    lim[i]      = int'($urandom_range(1, 4));
                    wait_cnt[i] = 0;
                end
            end
        end
        req_b = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
